// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared edge-mode encoding and counter width helper
package btn_cond_pkg;

  typedef enum logic [1:0] {
    MODE_RISE   = 2'd0,
    MODE_FALL   = 2'd1,
    MODE_BOTH   = 2'd2,
    MODE_REPEAT = 2'd3
  } edge_mode_e;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debounce, edge trigger, long-press and repeat
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 100000000,
  parameter int REPEAT_CYC   = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn,
  input  logic [1:0] i_edge_mode,
  output logic       o_level,
  output logic       o_trig,
  output logic       o_long
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(HOLD_CYC);
  localparam int RW = cnt_w(REPEAT_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic [RW-1:0] r_rcnt;
  logic          r_long_done;
  logic          r_trig;
  logic          r_long;

  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_long_hit;
  logic w_rep_hit;
  logic w_trig;

  // A level change is accepted on the edge the mismatch count reaches its limit.
  assign w_accept   = (r_sync1 != r_level) && (r_dcnt == D_LAST);
  assign w_rise     = w_accept &  r_sync1;
  assign w_fall     = w_accept & ~r_sync1;
  // Release on the same edge wins over both long-press and repeat.
  assign w_long_hit = r_level & ~w_fall & ~r_long_done & (r_hcnt == H_LAST);
  assign w_rep_hit  = r_level & ~w_fall & r_long_done & (r_rcnt == R_LAST);

  // Trigger selection uses the mode sampled on this very edge.
  always_comb begin
    w_trig = 1'b0;
    case (i_edge_mode)
      MODE_RISE:   w_trig = w_rise;
      MODE_FALL:   w_trig = w_fall;
      MODE_BOTH:   w_trig = w_rise | w_fall;
      MODE_REPEAT: w_trig = w_rise | w_rep_hit;
      default:     w_trig = 1'b0;
    endcase
  end

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce: any return to the current level restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_dcnt  <= '0;
    end else if (r_sync1 == r_level) begin
      r_dcnt  <= '0;
    end else if (w_accept) begin
      r_level <= r_sync1;
      r_dcnt  <= '0;
    end else begin
      r_dcnt  <= r_dcnt + DW'(1);
    end
  end

  // Hold counter runs until long-press fires, then the repeat counter takes over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt      <= '0;
      r_rcnt      <= '0;
      r_long_done <= 1'b0;
    end else if (w_rise || w_fall || !r_level) begin
      r_hcnt      <= '0;
      r_rcnt      <= '0;
      r_long_done <= 1'b0;
    end else if (!r_long_done) begin
      if (w_long_hit) begin
        r_long_done <= 1'b1;
        r_rcnt      <= '0;
      end else begin
        r_hcnt      <= r_hcnt + HW'(1);
      end
    end else if (r_rcnt == R_LAST) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + RW'(1);
    end
  end

  // Registered one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig <= 1'b0;
      r_long <= 1'b0;
    end else begin
      r_trig <= w_trig;
      r_long <= w_long_hit;
    end
  end

  assign o_level = r_level;
  assign o_trig  = r_trig;
  assign o_long  = r_long;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel push-button front end
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 100000000,
  parameter int REPEAT_CYC   = 20000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  input  logic [1:0]       edge_mode,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_trig,
  output logic [WIDTH-1:0] btn_long
);

  // Independent channels sharing one global edge mode.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_btn       (btn[g]),
      .i_edge_mode (edge_mode),
      .o_level     (btn_level[g]),
      .o_trig      (btn_trig[g]),
      .o_long      (btn_long[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - randomized scoreboard bench for btn_conditioner
module tb_btn_conditioner;

  localparam int W = 2;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] btn = '0;
  logic [1:0]   edge_mode = 2'd0;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_trig;
  logic [W-1:0] btn_long;

  always #5 clk = ~clk;

  btn_conditioner #(
    .WIDTH        (W),
    .DEBOUNCE_CYC (D),
    .HOLD_CYC     (H),
    .REPEAT_CYC   (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .edge_mode (edge_mode),
    .btn_level (btn_level),
    .btn_trig  (btn_trig),
    .btn_long  (btn_long)
  );

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] trig;
    logic [W-1:0] lng;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cnt_trig0 = 0;
  int    cnt_long0 = 0;
  longint edge_no = 0;

  // Reference model: timestamps of rise and long-press, pulses by arithmetic on edge numbers.
  int     m_s0[W];
  int     m_s1[W];
  int     m_lvl[W];
  int     m_run[W];
  bit     m_fired[W];
  longint m_rise_e[W];
  longint m_long_e[W];

  always @(posedge clk) begin : model
    exp_t e;
    int   s1_old;
    int   old_lvl;
    bit   rose, fell, lng, rep;
    e = '0;
    edge_no++;
    for (int c = 0; c < W; c++) begin
      if (!rst) begin
        m_s0[c] = 0; m_s1[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_fired[c] = 0;
      end else begin
        s1_old  = m_s1[c];
        m_s1[c] = m_s0[c];
        m_s0[c] = int'(btn[c]);
        old_lvl = m_lvl[c];
        rose = 0; fell = 0; lng = 0; rep = 0;
        if (s1_old != old_lvl) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = s1_old;
            m_run[c] = 0;
            rose = (s1_old == 1);
            fell = (s1_old == 0);
          end
        end else begin
          m_run[c] = 0;
        end
        if (rose) begin
          m_rise_e[c] = edge_no;
          m_fired[c]  = 0;
        end
        if (old_lvl == 1 && !fell && !m_fired[c] && edge_no == m_rise_e[c] + H) begin
          lng = 1;
          m_fired[c]  = 1;
          m_long_e[c] = edge_no;
        end
        if (old_lvl == 1 && !fell && m_fired[c] && edge_no > m_long_e[c] &&
            ((edge_no - m_long_e[c]) % R) == 0)
          rep = 1;
        e.lvl[c] = (m_lvl[c] == 1);
        e.lng[c] = lng;
        case (edge_mode)
          2'd0:    e.trig[c] = rose;
          2'd1:    e.trig[c] = fell;
          2'd2:    e.trig[c] = rose | fell;
          default: e.trig[c] = rose | (rep & ~lng);
        endcase
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: pops one expectation per clock edge and compares away from the edge.
  exp_t x;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at edge %0d", edge_no);
      end else begin
        x = exp_q.pop_front();
        if ({btn_level, btn_trig, btn_long} !== x) begin
          n_fail++;
          $display("FAIL outputs edge %0d: got lvl=%b trig=%b long=%b, want lvl=%b trig=%b long=%b",
                   edge_no, btn_level, btn_trig, btn_long, x.lvl, x.trig, x.lng);
        end
      end
      if (btn_trig[0]) cnt_trig0++;
      if (btn_long[0]) cnt_long0++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, btn_trig, btn_long} !== '0) begin
      n_fail++;
      $display("FAIL reset_clear: got lvl=%b trig=%b long=%b, want all 0", btn_level, btn_trig, btn_long);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  int bt, bl;

  initial begin
    cyc(3);
    rst = 1'b1;
    cyc(3);

    // Clean press in rise mode, then release
    edge_mode = 2'd0;
    btn[0] = 1'b1; cyc(8);
    btn[0] = 1'b0; cyc(10);

    // Bouncing press
    btn[0] = 1'b1; cyc(2);
    btn[0] = 1'b0; cyc(2);
    btn[0] = 1'b1; cyc(12);
    btn[0] = 1'b0; cyc(10);

    // Both-edges then fall-only
    edge_mode = 2'd2;
    btn[0] = 1'b1; cyc(8);
    btn[0] = 1'b0; cyc(10);
    edge_mode = 2'd1;
    btn[0] = 1'b1; cyc(8);
    btn[0] = 1'b0; cyc(10);

    // Long press with auto-repeat; release lands on a repeat slot, which must be suppressed
    edge_mode = 2'd3;
    bt = cnt_trig0; bl = cnt_long0;
    btn[0] = 1'b1; cyc(25);
    btn[0] = 1'b0; cyc(12);
    check_cnt("repeat_trig_count", cnt_trig0 - bt, 5);
    check_cnt("repeat_long_count", cnt_long0 - bl, 1);

    // Two channels pressed one cycle apart
    edge_mode = 2'd0;
    btn[0] = 1'b1; cyc(1);
    btn[1] = 1'b1; cyc(8);
    btn = '0; cyc(10);

    // Reset during the long-press count, then a fresh press
    edge_mode = 2'd3;
    bl = cnt_long0;
    btn[0] = 1'b1; cyc(12);
    pulse_reset();
    btn[0] = 1'b0;
    cyc(6);
    check_cnt("no_long_after_reset", cnt_long0 - bl, 0);
    bt = cnt_trig0; bl = cnt_long0;
    btn[0] = 1'b1; cyc(20);
    btn[0] = 1'b0; cyc(12);
    check_cnt("fresh_press_long", cnt_long0 - bl, 1);
    check_cnt("fresh_press_trig", cnt_trig0 - bt, 4);

    // Randomized traffic with mode changes and occasional resets
    for (int i = 0; i < 300; i++) begin
      btn = W'($urandom);
      if ($urandom_range(0, 3) == 0) edge_mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      cyc($urandom_range(1, 16));
    end
    btn = '0;
    cyc(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
